// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: tracked-entry layout and forwarding-select encoding.
package hazard_scoreboard_pkg;

    // Upper bound on the register index width; entries store indices zero-extended to this.
    localparam int SB_DEST_W = 8;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 wb_en;
        logic                 mem_r;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-source RAW match against the tracked producers, plus youngest-hit forwarding select.
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  sb_entry_t [DEPTH-2:0] ents,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      src,
    input  logic                  src_used,
    output logic [DEPTH-2:0]      hit,
    output logic [SEL_W-1:0]      sel
);

    always_comb begin
        sel = SEL_W'(FWD_RF);
        for (int k = 0; k < DEPTH-1; k++) begin
            hit[k] = ents[k].valid & ents[k].wb_en & (ents[k].dest == SB_DEST_W'(src))
                   & src_used & id_valid;
        end
        // Scan oldest to youngest so the youngest producer overrides.
        for (int k = DEPTH-2; k >= 0; k--) begin
            if (hit[k]) sel = SEL_W'(k+1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writes, drives freeze, registered forwarding selects
// and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W  = 4,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    input  logic [REG_W-1:0] src1,
    input  logic             src1_used,
    input  logic [REG_W-1:0] src2,
    input  logic             src2_used,
    input  logic             flush,
    output logic             freeze,
    output logic [SEL_W-1:0] fwd_sel1_q,
    output logic [SEL_W-1:0] fwd_sel2_q,
    output logic [CNT_W-1:0] stall_cnt
);

    // The WB slot (e[DEPTH-1]) can never hit or forward, so only e[0..DEPTH-2] are held.
    sb_entry_t [DEPTH-2:0]        ents_q;
    sb_entry_t                    id_entry;
    logic [1:0][REG_W-1:0]        srcs;
    logic [1:0]                   used;
    logic [1:0][DEPTH-2:0]        hits;
    logic [1:0][SEL_W-1:0]        sels;
    logic                         ld_hit;
    logic                         raw_hit;
    logic                         issue;

    assign srcs = {src2, src1};
    assign used = {src2_used, src1_used};

    for (genvar s = 0; s < 2; s++) begin : g_src
        sb_match #(
            .REG_W (REG_W),
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_match (
            .ents     (ents_q),
            .id_valid (id_valid),
            .src      (srcs[s]),
            .src_used (used[s]),
            .hit      (hits[s]),
            .sel      (sels[s])
        );
    end

    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.dest  = SB_DEST_W'(id_dest);
        id_entry.wb_en = id_wb_en;
        id_entry.mem_r = id_mem_r;

        ld_hit  = (hits[0][0] | hits[1][0]) & ents_q[0].mem_r;
        raw_hit = |hits;
        freeze  = ~flush & ((FWD_EN != 0) ? ld_hit : raw_hit);
        issue   = id_valid & ~freeze & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ents_q     <= '0;
            fwd_sel1_q <= '0;
            fwd_sel2_q <= '0;
            stall_cnt  <= '0;
        end else begin
            ents_q[0] <= issue ? id_entry : '0;
            for (int k = 1; k < DEPTH-1; k++) ents_q[k] <= ents_q[k-1];
            fwd_sel1_q <= (FWD_EN != 0 && issue) ? sels[0] : SEL_W'(FWD_RF);
            fwd_sel2_q <= (FWD_EN != 0 && issue) ? sels[1] : SEL_W'(FWD_RF);
            if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: three scoreboard configs on shared stimulus, checked each cycle against a timestamped producer model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_wb_en, id_mem_r, src1_used, src2_used, flush;
    logic [3:0] id_dest, src1, src2;

    logic        fz0, fz1, fz2;
    logic [1:0]  s10, s20, s11, s21, s12, s22;
    logic [15:0] c0, c1;
    logic [1:0]  c2;

    hazard_scoreboard #(.FWD_EN(0)) u_f0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .src1(src1), .src1_used(src1_used), .src2(src2),
        .src2_used(src2_used), .flush(flush), .freeze(fz0), .fwd_sel1_q(s10),
        .fwd_sel2_q(s20), .stall_cnt(c0));

    hazard_scoreboard #(.FWD_EN(1)) u_f1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .src1(src1), .src1_used(src1_used), .src2(src2),
        .src2_used(src2_used), .flush(flush), .freeze(fz1), .fwd_sel1_q(s11),
        .fwd_sel2_q(s21), .stall_cnt(c1));

    hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .src1(src1), .src1_used(src1_used), .src2(src2),
        .src2_used(src2_used), .flush(flush), .freeze(fz2), .fwd_sel1_q(s12),
        .fwd_sel2_q(s22), .stall_cnt(c2));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every issued register writer, stamped with the edge it entered EXE.
    // Its age (0 = EXE, 1 = MEM, ...) is simply the number of edges since then.
    typedef struct {
        int         cfg;
        int         pos;
        logic [3:0] dest;
        bit         mr;
    } rec_t;

    rec_t prod[$];
    int   now;
    int   stalls[2];
    int   selq1[2];
    int   selq2[2];
    bit   check_en = 1'b0;

    function automatic int age(input int i);
        return now - 1 - prod[i].pos;
    endfunction

    // Youngest producer of register s still able to cause a hazard, or -1.
    function automatic int find(input int c, input logic [3:0] s, input logic u);
        int best = -1;
        int bp = -1;
        if (!(id_valid && u)) return -1;
        foreach (prod[i])
            if (prod[i].cfg == c && prod[i].dest == s && age(i) <= DEPTH-2 && prod[i].pos > bp) begin
                best = i;
                bp = prod[i].pos;
            end
        return best;
    endfunction

    function automatic bit exp_freeze(input int c);
        int i1, i2;
        if (flush) return 1'b0;
        i1 = find(c, src1, src1_used);
        i2 = find(c, src2, src2_used);
        if (c == 0) return (i1 >= 0) || (i2 >= 0);
        return (i1 >= 0 && age(i1) == 0 && prod[i1].mr) || (i2 >= 0 && age(i2) == 0 && prod[i2].mr);
    endfunction

    function automatic int exp_sel(input int c, input logic [3:0] s, input logic u);
        int i;
        if (c == 0) return 0;
        i = find(c, s, u);
        return (i < 0) ? 0 : age(i) + 1;
    endfunction

    task automatic model_step();
        bit f[2];
        bit iss[2];
        int n1[2];
        int n2[2];
        for (int c = 0; c < 2; c++) begin
            f[c]   = exp_freeze(c);
            iss[c] = id_valid && !f[c] && !flush;
            n1[c]  = iss[c] ? exp_sel(c, src1, src1_used) : 0;
            n2[c]  = iss[c] ? exp_sel(c, src2, src2_used) : 0;
        end
        for (int c = 0; c < 2; c++) begin
            if (f[c]) stalls[c]++;
            selq1[c] = n1[c];
            selq2[c] = n2[c];
            if (iss[c] && id_wb_en) prod.push_back('{c, now, id_dest, id_mem_r});
        end
        now++;
        for (int i = prod.size() - 1; i >= 0; i--)
            if (age(i) > DEPTH) prod.delete(i);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("freeze_f0", 32'(fz0), 32'(exp_freeze(0)));
                chk("freeze_f1", 32'(fz1), 32'(exp_freeze(1)));
                chk("freeze_sat", 32'(fz2), 32'(exp_freeze(0)));
                chk("sel1_f0", 32'(s10), 32'(selq1[0]));
                chk("sel2_f0", 32'(s20), 32'(selq2[0]));
                chk("sel1_f1", 32'(s11), 32'(selq1[1]));
                chk("sel2_f1", 32'(s21), 32'(selq2[1]));
                chk("sel1_sat", 32'(s12), 32'(selq1[0]));
                chk("sel2_sat", 32'(s22), 32'(selq2[0]));
                chk("cnt_f0", 32'(c0), 32'(stalls[0] & 32'hffff));
                chk("cnt_f1", 32'(c1), 32'(stalls[1] & 32'hffff));
                chk("cnt_sat", 32'(c2), 32'((stalls[0] > 3) ? 3 : stalls[0]));
            end
        end
    end

    task automatic put(input logic v, input logic [3:0] d, input logic wb, input logic mr,
                       input logic [3:0] a, input logic ua, input logic [3:0] b, input logic ub,
                       input logic fl);
        id_valid = v;  id_dest = d;  id_wb_en = wb;  id_mem_r = mr;
        src1 = a;  src1_used = ua;  src2 = b;  src2_used = ub;  flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        rst = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        prod.delete();
        now = 0;
        stalls = '{0, 0};
        selq1 = '{0, 0};
        selq2 = '{0, 0};
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        check_en = 1'b1;
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin : main
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_freeze", 32'(fz1), 32'd0);
        chk("rst_cnt", 32'(c0), 32'd0);

        // Non-forwarding RAW: ADD R1 then reader of R1 stalls two cycles
        put(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        put(1, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("t1_f0_freeze_a", 32'(fz0), 32'd1);
        chk("t1_f1_nofreeze", 32'(fz1), 32'd0);
        tick();
        chk("t1_f1_sel1_mem", 32'(s11), 32'd1);
        @(negedge clk);
        chk("t1_f0_freeze_b", 32'(fz0), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_f0_release", 32'(fz0), 32'd0);
        tick();
        chk("t1_f0_sel1", 32'(s10), 32'd0);
        chk("t1_f0_cnt", 32'(c0), 32'd2);
        chk("t1_sat_cnt", 32'(c2), 32'd2);

        // Forwarding: back-to-back and one-apart
        do_reset();
        put(1, 2, 1, 0, 0, 0, 0, 0, 0); tick();
        put(1, 5, 1, 0, 0, 0, 2, 1, 0);
        @(negedge clk);
        chk("t2_nofreeze", 32'(fz1), 32'd0);
        tick();
        chk("t2_sel2_mem", 32'(s21), 32'd1);
        do_reset();
        put(1, 2, 1, 0, 0, 0, 0, 0, 0); tick();
        put(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        put(1, 5, 1, 0, 0, 0, 2, 1, 0); tick();
        chk("t2_sel2_wb", 32'(s21), 32'd2);

        // Load-use: one-cycle freeze then forward from WB
        do_reset();
        put(1, 3, 1, 1, 0, 0, 0, 0, 0); tick();
        put(1, 6, 1, 0, 3, 1, 0, 0, 0);
        @(negedge clk);
        chk("t3_ld_freeze", 32'(fz1), 32'd1);
        tick();
        @(negedge clk);
        chk("t3_ld_release", 32'(fz1), 32'd0);
        tick();
        chk("t3_sel1_wb", 32'(s11), 32'd2);
        chk("t3_cnt", 32'(c1), 32'd1);

        // Dual match: youngest wins
        do_reset();
        put(1, 4, 1, 0, 0, 0, 0, 0, 0); tick();
        tick();
        put(1, 7, 1, 0, 4, 1, 0, 0, 0); tick();
        chk("t4_youngest", 32'(s11), 32'd1);

        // Flush during load-use
        do_reset();
        put(1, 3, 1, 1, 0, 0, 0, 0, 0); tick();
        put(1, 6, 1, 0, 3, 1, 0, 0, 1);
        @(negedge clk);
        chk("t5_flush_freeze", 32'(fz1), 32'd0);
        tick();
        chk("t5_flush_sel", 32'(s11), 32'd0);
        put(1, 6, 1, 0, 3, 1, 0, 0, 0);
        @(negedge clk);
        chk("t5_after_freeze", 32'(fz1), 32'd0);
        tick();
        chk("t5_after_sel", 32'(s11), 32'd2);
        chk("t5_cnt", 32'(c1), 32'd0);

        // Asynchronous reset mid-stall
        do_reset();
        put(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        put(1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        @(negedge clk);
        chk("t6_pre_freeze", 32'(fz0), 32'd1);
        check_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t6_freeze", 32'(fz0), 32'd0);
        chk("t6_cnt", 32'(c0), 32'd0);
        chk("t6_sel1_f1", 32'(s11), 32'd0);
        chk("t6_sat_cnt", 32'(c2), 32'd0);

        // Dependency chain: 6 stalls, 2-bit counter saturates at 3
        do_reset();
        put(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        for (int r = 1; r <= 3; r++) begin
            put(1, 4'(r + 1), 1, 0, 4'(r), 1, 0, 0, 0);
            repeat (3) tick();
        end
        chk("t7_cnt", 32'(c0), 32'd6);
        chk("t7_sat", 32'(c2), 32'd3);

        // Randomized traffic with dense register reuse
        do_reset();
        repeat (3000) begin
            put(($urandom_range(0, 99) < 85), rreg(), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), rreg(), ($urandom_range(0, 3) != 0),
                rreg(), ($urandom_range(0, 1) != 0), ($urandom_range(0, 9) == 0));
            tick();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational hazard detector.
- Tracks in-flight register writes in a DEPTH-entry shift register, with entry 0 = EXE, 1 = MEM, …, DEPTH-1 = WB.
- Generates freeze for the ID stage. In forwarding mode it also generates registered forwarding selects consumed by EXE.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_W, 4, register index width.
- DEPTH, 3, tracked post-ID stages (legal 2..4).
- FWD_EN, 1. 0 = stall on any RAW; 1 = forward, stall only on load-use.
- SEL_W, 2, forwarding-select width (must be at least clog2(DEPTH)).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_dest  in  REG_W  destination of ID instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_r  in  1  ID instruction is a load.
- src1  in  REG_W  Rn index.
- src1_used  in  1  Rn is read.
- src2  in  REG_W  Rm or Rd (store) index.
- src2_used  in  1  second source is read (MEM_W or non-imm).
- flush  in  1  branch taken in EXE; kill ID instruction.
- freeze  out  1  hold PC and IF/ID register; combinational.
- fwd_sel1_q  out  SEL_W  EXE Rn source: 0 = RF, 1 = MEM, 2 = WB, k = stage k.
- fwd_sel2_q  out  SEL_W  EXE second-source select; same encoding.
- stall_cnt  out  CNT_W  saturating count of freeze cycles.

Behaviour:
- Entry fields: valid, dest, wb_en, mem_r. A hit on entry k for source s means valid & wb_en & (dest == s) & s_used & id_valid.
- Each rising edge:
  - entries shift, e[k] <= e[k-1];
  - e[0] <= ID instruction if id_valid & !freeze & !flush, else a bubble (valid=0);
  - the oldest entry is discarded.
- FWD_EN=0: freeze = hit on any of e[0..DEPTH-2]. e[DEPTH-1] is covered by register-file write-before-read. fwd_sel*_q is held at 0.
- FWD_EN=1: freeze = hit on e[0] with e[0].mem_r (load-use). No other freeze.
- FWD_EN=1 select computation, per source, for the ID instruction:
  - the youngest hitting entry k in 0..DEPTH-2 gives select k+1, since that producer will be in stage k+1 when the consumer is in EXE;
  - no hit gives 0;
  - the youngest entry wins when several match.
- fwd_sel*_q registers the computed select on each edge where the ID instruction enters e[0]. Otherwise fwd_sel*_q <= 0 (bubble into EXE).
- flush has priority:
  - freeze is forced 0 while flush=1;
  - e[0] and fwd_sel*_q take bubble/0;
  - e[1..] shift normally.
- Register index 15 (PC) is treated like any other register; no special case.
- stall_cnt increments by 1 on each edge where freeze=1, and saturates at all-ones.
- Reset (rst low, asynchronous):
  - all entries invalid;
  - fwd_sel*_q = 0;
  - stall_cnt = 0;
  - freeze = 0 because no entries are valid.
- Reset asserted mid-stall clears the stall immediately.
- After a load-use freeze, the load is in e[1]. Next cycle the consumer issues with select 2 (WB), so the freeze lasts exactly 1 cycle.

Decomposition:
- Shared pipeline package holds:
  - entry struct {valid, dest, wb_en, mem_r};
  - select encoding constants FWD_RF=0, FWD_MEM=1, FWD_WB=2.
- One natural sub-module, sb_match: combinational per-source hit vector plus youngest-hit priority encoder. It is instantiated twice (src1, src2).

Test Plan:
- FWD_EN=0: issue ADD R1 (wb_en). Next cycle ID reads src1=R1 -> freeze=1 for 2 cycles, fwd_sel1_q=0, then issue; stall_cnt=2.
- FWD_EN=1: ADD R2, then SUB reading R2 in src2 -> freeze never 1; SUB in EXE with fwd_sel2_q=1. With one independent instruction between them -> fwd_sel2_q=2.
- FWD_EN=1: LDR R3, then ADD reading R3 -> freeze=1 exactly 1 cycle; ADD enters EXE with fwd_sel1_q=2; stall_cnt=1.
- Dual match: ADD R4 twice back-to-back, then reader of R4 -> fwd_sel1_q=1 (youngest wins).
- Flush during load-use freeze -> freeze drops to 0 that cycle, e[0] bubble, fwd_sel*_q=0, earlier entries still retire.
- Assert rst low mid-freeze, asynchronously, off a clock edge -> freeze, fwd_sel*_q and stall_cnt are 0 immediately. With CNT_W=2, 5 stall cycles -> stall_cnt=3 (saturated).
